// File: rtl/spi_nor_responder.sv
// SPI-NOR flash target model (mode 0, MSB first), fully synchronous to p_clk.
// s_clk/s_css/s_mosi are oversampled through 2-flop synchronizers and edge-detected;
// the serial clock is never used as a clock. Serves READ, PP, RDSR, WREN, WRDI
// from a small byte array that resets to the erased value 8'hFF.
`timescale 1ns/1ps
module spi_nor_responder #(
  parameter int MEM_DEPTH   = 64,
  parameter int PAGE_SIZE   = 16,
  parameter int PROG_CYCLES = 32
) (
  input  logic p_clk,
  input  logic p_rst_n,
  input  logic s_clk,
  input  logic s_css,
  input  logic s_mosi,
  output logic s_miso,
  output logic wip
);

  localparam int AW  = $clog2(MEM_DEPTH);
  // shift register holds enough bits for either an opcode or the used address bits
  localparam int SW  = (AW > 8) ? AW : 8;
  localparam int PCW = $clog2(PROG_CYCLES + 1);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);

  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD, WR, STATUS, IGNORE
  } state_t;

  logic [1:0]     clk_sync, css_sync, mosi_sync;
  logic           clk_d, css_d;
  logic           clk_s, css_s, mosi_s;
  logic           sclk_rise, sclk_fall, css_rise, css_fall;

  state_t         state;
  logic [4:0]     bit_cnt;
  logic [SW-2:0]  shreg;
  logic [SW-1:0]  sh_next;
  logic [7:0]     cmd;
  logic           is_read;
  logic [AW-1:0]  addr, addr_inc, page_next;
  logic [7:0]     tx_byte;
  logic [7:0]     status;
  logic           wel;
  logic [PCW-1:0] prog_cnt;
  logic           got_byte;
  logic [7:0]     mem [MEM_DEPTH];

  // input synchronizers plus one extra stage on clk/css for edge detection
  always_ff @(posedge p_clk or negedge p_rst_n) begin
    if (!p_rst_n) begin
      clk_sync  <= 2'b00;
      css_sync  <= 2'b11;
      mosi_sync <= 2'b00;
      clk_d     <= 1'b0;
      css_d     <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], s_clk};
      css_sync  <= {css_sync[0], s_css};
      mosi_sync <= {mosi_sync[0], s_mosi};
      clk_d     <= clk_sync[1];
      css_d     <= css_sync[1];
    end
  end

  // edge strobes, incoming-bit shift value and address arithmetic
  always_comb begin
    clk_s     = clk_sync[1];
    css_s     = css_sync[1];
    mosi_s    = mosi_sync[1];
    sclk_rise = clk_s & ~clk_d;
    sclk_fall = ~clk_s & clk_d;
    css_rise  = css_s & ~css_d;
    css_fall  = ~css_s & css_d;
    sh_next   = {shreg, mosi_s};
    cmd       = sh_next[7:0];
    addr_inc  = addr + 1'b1;
    // page program stays inside its page: only the low page bits advance
    page_next = (addr & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
    status    = {6'b0, wel, wip};
  end

  // frame FSM, status bits, program timer and storage array
  always_ff @(posedge p_clk or negedge p_rst_n) begin
    if (!p_rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      is_read  <= 1'b0;
      addr     <= '0;
      tx_byte  <= '0;
      wel      <= 1'b0;
      wip      <= 1'b0;
      prog_cnt <= '0;
      got_byte <= 1'b0;
      s_miso   <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'hFF;
    end else begin
      // program busy timer; WEL drops together with WIP when programming ends
      if (wip) begin
        if (prog_cnt == '0) begin
          wip <= 1'b0;
          wel <= 1'b0;
        end else begin
          prog_cnt <= prog_cnt - 1'b1;
        end
      end

      if (css_s) begin
        // deselected: any clock edge seen in this cycle is dropped on purpose
        state    <= IDLE;
        bit_cnt  <= '0;
        s_miso   <= 1'b0;
        got_byte <= 1'b0;
        if (css_rise && state == WR && wel && got_byte) begin
          wip      <= 1'b1;
          prog_cnt <= PCW'(PROG_CYCLES - 1);
        end
      end else begin
        case (state)
          IDLE: begin
            if (css_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end

          CMD: begin
            if (sclk_rise) begin
              shreg   <= sh_next[SW-2:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (wip && cmd != OP_RDSR) begin
                  state <= IGNORE;
                end else begin
                  case (cmd)
                    OP_WREN: begin wel <= 1'b1; state <= IGNORE; end
                    OP_WRDI: begin wel <= 1'b0; state <= IGNORE; end
                    OP_RDSR: begin state <= STATUS; tx_byte <= status; end
                    OP_READ: begin state <= ADDR; is_read <= 1'b1; end
                    OP_PP:   begin state <= ADDR; is_read <= 1'b0; end
                    default: state <= IGNORE;
                  endcase
                end
              end
            end
          end

          ADDR: begin
            if (sclk_rise) begin
              shreg   <= sh_next[SW-2:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                addr    <= sh_next[AW-1:0];
                if (is_read) begin
                  state   <= RD;
                  tx_byte <= mem[sh_next[AW-1:0]];
                end else begin
                  state   <= WR;
                end
              end
            end
          end

          RD, STATUS: begin
            // shift out on the falling edge; reload on the last bit of each byte
            if (sclk_fall) begin
              s_miso  <= tx_byte[7];
              tx_byte <= {tx_byte[6:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (state == RD) begin
                  addr    <= addr_inc;
                  tx_byte <= mem[addr_inc];
                end else begin
                  tx_byte <= status;
                end
              end
            end
          end

          WR: begin
            if (sclk_rise) begin
              shreg   <= sh_next[SW-2:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                got_byte <= 1'b1;
                addr     <= page_next;
                // NOR cells can only be cleared by programming
                if (wel) mem[addr] <= mem[addr] & cmd;
              end
            end
          end

          default: ;  // IGNORE: hold s_miso low until deselect
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_nor_responder.sv
// Bench for spi_nor_responder: directed scenarios plus randomized program/read
// traffic, checked against a byte-array flash model kept in the bench.
`timescale 1ns/1ps
module tb_spi_nor_responder;

  localparam int DEPTH = 64;
  localparam int PAGE  = 16;
  localparam int PROG  = 1200;  // long enough to run whole frames while busy
  localparam int HALF  = 4;     // p_clk cycles per s_clk half period

  logic p_clk = 1'b0;
  logic p_rst_n = 1'b0;
  logic s_clk = 1'b0;
  logic s_css = 1'b1;
  logic s_mosi = 1'b0;
  logic s_miso;
  logic wip;

  spi_nor_responder #(.MEM_DEPTH(DEPTH), .PAGE_SIZE(PAGE), .PROG_CYCLES(PROG)) dut (
    .p_clk  (p_clk),
    .p_rst_n(p_rst_n),
    .s_clk  (s_clk),
    .s_css  (s_css),
    .s_mosi (s_mosi),
    .s_miso (s_miso),
    .wip    (wip)
  );

  always #5 p_clk = ~p_clk;

  int checks = 0;
  int errors = 0;

  // reference flash: contents, write-enable latch, program-in-progress
  logic [7:0] mem_m [DEPTH];
  logic       wel_m;
  logic       busy_m;
  logic [7:0] pp_data [8];

  int wip_cycles = 0;
  always @(posedge p_clk) if (wip === 1'b1) wip_cycles <= wip_cycles + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
    wel_m  = 1'b0;
    busy_m = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge p_clk);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      s_mosi = tx[i];
      wait_cyc(HALF);
      rx = {rx[6:0], s_miso};
      s_clk = 1'b1;
      wait_cyc(HALF);
      s_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    s_css = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic cs_high();
    wait_cyc(HALF);
    s_css  = 1'b1;
    s_mosi = 1'b0;
    wait_cyc(2 * HALF);
  endtask

  task automatic op_only(input logic [7:0] op, input string tag);
    logic [7:0] rx;
    cs_low();
    xfer(op, rx);
    chk(tag, rx, 0);
    cs_high();
    if (!busy_m) begin
      if (op == 8'h06) wel_m = 1'b1;
      if (op == 8'h04) wel_m = 1'b0;
    end
  endtask

  task automatic rdsr(input int n, input string tag);
    logic [7:0] rx;
    cs_low();
    xfer(8'h05, rx);
    chk({tag, "_cmd"}, rx, 0);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      chk(tag, rx, {6'b0, wel_m, busy_m});
    end
    cs_high();
  endtask

  task automatic send_addr(input logic [23:0] a, input string tag);
    logic [7:0] rx;
    for (int i = 2; i >= 0; i--) begin
      xfer(a[8*i +: 8], rx);
      chk({tag, "_addr"}, rx, 0);
    end
  endtask

  task automatic read_chk(input logic [23:0] a, input int n, input string tag);
    logic [7:0] rx;
    int base;
    base = int'(a) % DEPTH;
    cs_low();
    xfer(8'h03, rx);
    chk({tag, "_cmd"}, rx, 0);
    send_addr(a, tag);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      chk(tag, rx, busy_m ? 8'h00 : mem_m[(base + i) % DEPTH]);
    end
    cs_high();
  endtask

  task automatic pp(input logic [23:0] a, input int n, input string tag);
    logic [7:0] rx;
    int base, idx;
    logic accept;
    accept = !busy_m && wel_m;
    base = int'(a) % DEPTH;
    cs_low();
    xfer(8'h02, rx);
    chk({tag, "_cmd"}, rx, 0);
    send_addr(a, tag);
    for (int i = 0; i < n; i++) begin
      xfer(pp_data[i], rx);
      chk({tag, "_data"}, rx, 0);
      if (accept) begin
        idx = (base & ~(PAGE - 1)) | ((base + i) & (PAGE - 1));
        mem_m[idx] = mem_m[idx] & pp_data[i];
      end
    end
    cs_high();
    if (accept && n >= 1) busy_m = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (wip !== 1'b0 && t < PROG + 200) begin
      wait_cyc(1);
      t++;
    end
    chk(tag, wip, 0);
    if (busy_m) begin
      busy_m = 1'b0;
      wel_m  = 1'b0;
    end
    wait_cyc(4);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [7:0] rx;
    logic [7:0] op;
    logic [23:0] a;
    int n;

    model_reset();
    wait_cyc(4);
    p_rst_n = 1'b1;
    wait_cyc(4);

    // 1: reset state, status, erased array
    chk("rst_miso", s_miso, 0);
    chk("rst_wip", wip, 0);
    rdsr(1, "t1_rdsr");
    read_chk(24'h000000, 2, "t1_read");

    // 2: write-enable latch set and clear
    op_only(8'h06, "t2_wren");
    rdsr(1, "t2_rdsr_wel");
    op_only(8'h04, "t2_wrdi");
    rdsr(1, "t2_rdsr_clr");

    // 3: committed page program, busy status, busy duration
    op_only(8'h06, "t3_wren");
    pp_data[0] = 8'hA5; pp_data[1] = 8'h3C;
    w0 = wip_cycles;
    pp(24'h000010, 2, "t3_pp");
    chk("t3_wip_set", wip, 1);
    rdsr(2, "t3_rdsr_busy");
    wait_idle("t3_idle");
    chk("t3_wip_len", wip_cycles - w0, PROG);
    rdsr(1, "t3_rdsr_done");
    read_chk(24'h000010, 3, "t3_read");

    // 4: program without write enable has no effect
    w0 = wip_cycles;
    pp_data[0] = 8'h00;
    pp(24'h000020, 1, "t4_pp");
    wait_cyc(50);
    chk("t4_no_wip", wip_cycles - w0, 0);
    read_chk(24'h000020, 1, "t4_read");

    // 5: page wrap inside the program, array wrap on read
    op_only(8'h06, "t5_wren");
    pp_data[0] = 8'h11; pp_data[1] = 8'h22;
    pp(24'h00001F, 2, "t5_pp");
    wait_idle("t5_idle");
    read_chk(24'h00001F, 1, "t5_read_1f");
    read_chk(24'h000010, 1, "t5_read_10");
    read_chk(24'h00003F, 2, "t5_read_wrap");

    // 6: commands ignored while busy, aborted command leaves no residue
    op_only(8'h06, "t6_wren");
    pp_data[0] = 8'h0F;
    pp(24'h000030, 1, "t6_pp");
    read_chk(24'h000010, 2, "t6_read_busy");
    cs_low();
    for (int i = 0; i < 5; i++) begin
      s_mosi = 1'b0;
      wait_cyc(HALF);
      s_clk = 1'b1;
      wait_cyc(HALF);
      s_clk = 1'b0;
    end
    cs_high();
    rdsr(2, "t6_rdsr_busy");
    wait_idle("t6_idle");
    rdsr(1, "t6_rdsr_done");
    read_chk(24'h000030, 1, "t6_read");

    // PP with zero data bytes: no program, WEL kept
    op_only(8'h06, "pp0_wren");
    pp(24'h000005, 0, "pp0_pp");
    chk("pp0_wip", wip, 0);
    rdsr(1, "pp0_rdsr");
    op_only(8'h04, "pp0_wrdi");

    // randomized traffic against the model
    for (int it = 0; it < 12; it++) begin
      do op = 8'($urandom_range(0, 255)); while (op >= 8'h02 && op <= 8'h06);
      cs_low();
      xfer(op, rx);
      chk("rnd_badop_cmd", rx, 0);
      xfer(8'($urandom), rx);
      chk("rnd_badop_data", rx, 0);
      cs_high();
      if ($urandom_range(0, 3) != 0) op_only(8'h06, "rnd_wren");
      if ($urandom_range(0, 5) == 0) op_only(8'h04, "rnd_wrdi");
      a = 24'($urandom);
      n = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) pp_data[i] = 8'($urandom | $urandom);
      pp(a, n, "rnd_pp");
      if (busy_m) wait_idle("rnd_idle");
      rdsr(1, "rnd_rdsr");
      read_chk(a, n + 1, "rnd_read_pp");
      read_chk(24'($urandom), $urandom_range(1, 4), "rnd_read");
    end

    // reset in the middle of a program frame
    op_only(8'h06, "mid_wren");
    cs_low();
    xfer(8'h02, rx);
    send_addr(24'h000000, "mid_pp");
    xfer(8'h00, rx);
    for (int i = 0; i < 3; i++) begin
      s_mosi = 1'b1;
      wait_cyc(HALF);
      s_clk = 1'b1;
      wait_cyc(HALF);
      s_clk = 1'b0;
    end
    p_rst_n = 1'b0;
    wait_cyc(3);
    s_css  = 1'b1;
    s_mosi = 1'b0;
    wait_cyc(2);
    p_rst_n = 1'b1;
    model_reset();
    wait_cyc(8);
    chk("mid_wip", wip, 0);
    chk("mid_miso", s_miso, 0);
    read_chk(24'h000000, 2, "mid_read");
    rdsr(1, "mid_rdsr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
